// File: rtl/uart_tx_frame_module.sv
// uart_tx_frame_module: UART transmit framer (start, LSB-first data, optional parity, stop)
// stepped by one-cycle Baudclk pulses from an external baud-rate generator.
module uart_tx_frame_module #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 Tx_Req,
  input  logic [DATA_BITS-1:0] Tx_Data,
  input  logic [1:0]           Check,
  input  logic                 Baudclk,
  output logic                 Baud_En,
  output logic                 Txd,
  output logic                 Busy,
  output logic                 Done
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t r_state, w_state;
  logic [DATA_BITS-1:0] r_shift, w_shift;
  logic [2:0] r_bcnt, w_bcnt;
  logic r_scnt, w_scnt;
  logic r_par_en, w_par_en, r_par, w_par;
  logic r_txd, w_txd, r_baud_en, w_baud_en, r_busy, w_busy, r_done, w_done;
  logic w_last_data, w_last_stop;
  assign w_last_data = r_bcnt == 3'(DATA_BITS - 1);
  assign w_last_stop = r_scnt == 1'(STOP_BITS - 1);
  assign Txd = r_txd;
  assign Baud_En = r_baud_en;
  assign Busy = r_busy;
  assign Done = r_done;
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bcnt <= '0;
      r_scnt <= 1'b0;
      r_par_en <= 1'b0;
      r_par <= 1'b0;
      r_txd <= 1'b1;
      r_baud_en <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_state;
      r_shift <= w_shift;
      r_bcnt <= w_bcnt;
      r_scnt <= w_scnt;
      r_par_en <= w_par_en;
      r_par <= w_par;
      r_txd <= w_txd;
      r_baud_en <= w_baud_en;
      r_busy <= w_busy;
      r_done <= w_done;
    end
  end
  // Parity is resolved at acceptance so later Tx_Data/Check changes cannot reach the frame.
  always_comb begin
    w_state = r_state;
    w_shift = r_shift;
    w_bcnt = r_bcnt;
    w_scnt = r_scnt;
    w_par_en = r_par_en;
    w_par = r_par;
    w_txd = r_txd;
    w_baud_en = r_baud_en;
    w_busy = r_busy;
    w_done = 1'b0;
    case (r_state)
      IDLE: if (Tx_Req) begin
        w_state = START;
        w_shift = Tx_Data;
        w_par_en = Check[0] ^ Check[1];
        w_par = Check[0] ? ~^Tx_Data : ^Tx_Data;
        w_txd = 1'b0;
        w_baud_en = 1'b1;
        w_busy = 1'b1;
      end
      START: if (Baudclk) begin
        w_state = DATA;
        w_txd = r_shift[0];
      end
      DATA: if (Baudclk) begin
        w_shift = r_shift >> 1;
        w_bcnt = w_last_data ? 3'd0 : r_bcnt + 3'd1;
        w_state = w_last_data ? (r_par_en ? PARITY : STOP) : DATA;
        w_txd = w_last_data ? (r_par_en ? r_par : 1'b1) : r_shift[1];
      end
      PARITY: if (Baudclk) begin
        w_state = STOP;
        w_txd = 1'b1;
      end
      STOP: if (Baudclk) begin
        w_scnt = w_last_stop ? 1'b0 : r_scnt + 1'b1;
        if (w_last_stop) begin
          w_state = IDLE;
          w_baud_en = 1'b0;
          w_busy = 1'b0;
          w_done = 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_frame_module.sv
`timescale 1ns/1ps
// tb_uart_tx_frame_module: scoreboard bench for two framer variants (8N1-style and 7-bit/2-stop)
// each fed by a behavioural baud generator; frames are decoded per bit period and compared.
module tb_uart_tx_frame_module;
  typedef struct { logic [11:0] bits; int n; int gap; bit abort; } exp_t;
  logic CLK = 1'b0, RSTn = 1'b0;
  logic [1:0] req = 2'b00, kick = 2'b00;
  logic [7:0] data [2];
  logic [1:0] chk [2];
  int bcnt [2];
  logic [15:0] cnt [2];
  wire txd0, txd1, busy0, busy1, done0, done1, en0, en1;
  wire [1:0] txd = {txd1, txd0};
  wire [1:0] busy = {busy1, busy0};
  wire [1:0] done = {done1, done0};
  wire [1:0] en = {en1, en0};
  wire bclk0 = (en0 && cnt[0] == 16'(bcnt[0] - 1)) || kick[0];
  wire bclk1 = (en1 && cnt[1] == 16'(bcnt[1] - 1)) || kick[1];
  exp_t sb [2][$];
  int n_tot = 0, n_bad = 0;
  always #10 CLK = ~CLK;
  uart_tx_frame_module #(.DATA_BITS(8), .STOP_BITS(1)) u0 (
    .CLK(CLK), .RSTn(RSTn), .Tx_Req(req[0]), .Tx_Data(data[0]), .Check(chk[0]),
    .Baudclk(bclk0), .Baud_En(en0), .Txd(txd0), .Busy(busy0), .Done(done0)
  );
  uart_tx_frame_module #(.DATA_BITS(7), .STOP_BITS(2)) u1 (
    .CLK(CLK), .RSTn(RSTn), .Tx_Req(req[1]), .Tx_Data(data[1][6:0]), .Check(chk[1]),
    .Baudclk(bclk1), .Baud_En(en1), .Txd(txd1), .Busy(busy1), .Done(done1)
  );
  // Baud generator: held at 0 while disabled, pulses every bcnt cycles once enabled.
  always @(posedge CLK or negedge RSTn)
    for (int i = 0; i < 2; i++)
      if (!RSTn) cnt[i] <= '0;
      else if (!en[i] || cnt[i] == 16'(bcnt[i] - 1)) cnt[i] <= '0;
      else cnt[i] <= cnt[i] + 16'd1;
  task automatic check(input int i, input string nm, input logic [31:0] act, input logic [31:0] want);
    n_tot++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0d want %0d", nm, i, act, want);
    end
  endtask
  function automatic exp_t model(input int i, input logic [7:0] d, input logic [1:0] c, input int gap, input bit abort);
    int db = i ? 7 : 8;
    int nstop = i ? 2 : 1;
    int ones = 0;
    exp_t e;
    e.bits = '0;
    e.n = 1;
    e.gap = gap;
    e.abort = abort;
    for (int k = 0; k < db; k++) begin
      e.bits[e.n] = d[k];
      ones += int'(d[k]);
      e.n++;
    end
    if (c == 2'd1 || c == 2'd2) begin
      e.bits[e.n] = (c == 2'd1) ? (ones % 2 == 0) : (ones % 2 == 1);
      e.n++;
    end
    for (int k = 0; k < nstop; k++) begin
      e.bits[e.n] = 1'b1;
      e.n++;
    end
    return e;
  endfunction
  task automatic monitor(input int i);
    int gap = -1;
    logic s [$];
    bit ok;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RSTn) begin
        gap = -1;
        continue;
      end
      check(i, "done_extra", done[i], 0);
      if (!busy[i]) begin
        check(i, "idle_line", {txd[i], en[i]}, 2'b10);
        if (gap >= 0) gap++;
        continue;
      end
      s.delete();
      ok = 1;
      while (busy[i] && RSTn) begin
        s.push_back(txd[i]);
        if (!en[i]) ok = 0;
        @(negedge CLK);
      end
      if (sb[i].size() == 0) begin
        n_tot++;
        n_bad++;
        $display("FAIL unexpected_frame dut%0d: got %0d-cycle frame want none", i, s.size());
        gap = -1;
        continue;
      end
      e = sb[i].pop_front();
      check(i, "abort", !RSTn, e.abort);
      if (!RSTn) begin
        gap = -1;
        continue;
      end
      check(i, "frame_len", s.size(), e.n * bcnt[i]);
      for (int k = 0; k < s.size(); k++)
        if (k / bcnt[i] >= e.n || s[k] !== e.bits[k / bcnt[i]]) ok = 0;
      check(i, "frame_bits", ok, 1);
      check(i, "done_pulse", {done[i], txd[i], en[i]}, 3'b110);
      if (e.gap >= 0) check(i, "idle_gap", gap, e.gap);
      gap = 1;
    end
  endtask
  initial monitor(0);
  initial monitor(1);
  task automatic send(input int i, input int b, input logic [7:0] d, input logic [1:0] c, input bit mid);
    exp_t e;
    do @(negedge CLK); while (busy[i]);
    @(negedge CLK);
    bcnt[i] = b;
    kick[i] = 1'($urandom_range(0, 1));
    data[i] = d;
    chk[i] = c;
    req[i] = 1'b1;
    e = model(i, d, c, -1, 0);
    sb[i].push_back(e);
    @(negedge CLK);
    req[i] = 1'b0;
    kick[i] = 1'b0;
    data[i] = 8'($urandom);
    chk[i] = 2'($urandom);
    if (mid) begin
      repeat (e.n * b / 2) @(negedge CLK);
      data[i] = 8'hAA;
      req[i] = 1'b1;
      @(negedge CLK);
      req[i] = 1'b0;
    end
  endtask
  task automatic b2b(input int i, input int b);
    exp_t a;
    do @(negedge CLK); while (busy[i]);
    @(negedge CLK);
    bcnt[i] = b;
    data[i] = 8'($urandom);
    chk[i] = 2'($urandom);
    a = model(i, data[i], chk[i], -1, 0);
    sb[i].push_back(a);
    req[i] = 1'b1;
    @(negedge CLK);
    data[i] = 8'($urandom);
    chk[i] = 2'($urandom);
    sb[i].push_back(model(i, data[i], chk[i], 1, 0));
    repeat (a.n * b + 1) @(negedge CLK);
    req[i] = 1'b0;
  endtask
  task automatic rst_mid(input int i, input int b);
    do @(negedge CLK); while (busy[i]);
    @(negedge CLK);
    bcnt[i] = b;
    data[i] = 8'($urandom);
    chk[i] = 2'($urandom);
    sb[i].push_back(model(i, data[i], chk[i], -1, 1));
    req[i] = 1'b1;
    @(negedge CLK);
    req[i] = 1'b0;
    repeat (4 * b + b / 2) @(negedge CLK);
    #3 RSTn = 1'b0;
    #1;
    check(i, "rst_async", {txd[i], busy[i], en[i], done[i]}, 4'b1000);
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion by 1 ms want completion");
    $fatal(1);
  end
  initial begin
    data[0] = '0;
    data[1] = '0;
    chk[0] = '0;
    chk[1] = '0;
    bcnt[0] = 434;
    bcnt[1] = 434;
    repeat (3) @(negedge CLK);
    check(0, "reset", {txd0, en0, busy0, done0}, 4'b1000);
    check(1, "reset", {txd1, en1, busy1, done1}, 4'b1000);
    RSTn = 1'b1;
    send(0, 434, 8'h55, 2'd0, 1);
    send(0, 8, 8'h07, 2'd1, 0);
    send(0, 8, 8'h00, 2'd1, 0);
    send(0, 8, 8'h07, 2'd2, 0);
    send(0, 8, 8'h07, 2'd3, 0);
    b2b(0, 6);
    rst_mid(0, 8);
    send(0, 5, 8'hC3, 2'd1, 0);
    send(1, 434, 8'h41, 2'd0, 0);
    b2b(1, 5);
    repeat (12) begin
      send(0, int'($urandom_range(3, 12)), 8'($urandom), 2'($urandom), 0);
      send(1, int'($urandom_range(3, 12)), 8'($urandom), 2'($urandom), 0);
    end
    for (int i = 0; i < 2; i++) begin
      do @(negedge CLK); while (busy[i]);
    end
    repeat (3) @(negedge CLK);
    check(0, "sb_empty", sb[0].size(), 0);
    check(1, "sb_empty", sb[1].size(), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
